// File: rtl/stream_fifo_v2.sv
// Stream FIFO: DEPTH-entry memory followed by a registered output stage,
// giving DEPTH+1 words of capacity with level and almost-full/empty flags.
module stream_fifo_v2 #(
    parameter int W         = 16,
    parameter int LGFLEN    = 7,
    parameter int AF_THRESH = (2 ** LGFLEN) - 4,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [W-1:0]      s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [W-1:0]      m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LGFLEN:0]   level,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int DEPTH = 2 ** LGFLEN;
    localparam logic [LGFLEN:0]   FULL_CNT = (LGFLEN + 1)'(DEPTH);
    localparam logic [LGFLEN:0]   AF_LVL   = (LGFLEN + 1)'(AF_THRESH);
    localparam logic [LGFLEN:0]   AE_LVL   = (LGFLEN + 1)'(AE_THRESH);
    localparam logic [LGFLEN-1:0] PTR_ONE  = {{(LGFLEN - 1){1'b0}}, 1'b1};
    localparam logic [LGFLEN:0]   CNT_ONE  = {{LGFLEN{1'b0}}, 1'b1};

    logic [W-1:0]      r_mem [DEPTH];
    logic [LGFLEN-1:0] r_wr_ptr;
    logic [LGFLEN-1:0] r_rd_ptr;
    logic [LGFLEN:0]   r_mem_count;
    logic [W-1:0]      r_m_data;
    logic              r_m_valid;

    logic w_push;
    logic w_load;

    // s_ready deliberately ignores m_ready: a full memory blocks pushes even on a pop cycle.
    assign s_ready = (r_mem_count != FULL_CNT) && !flush;
    assign w_push  = s_valid && s_ready;
    assign w_load  = (!r_m_valid || m_ready) && (r_mem_count != '0);

    // Memory has no reset; only pointers and flags are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_mem_count <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_mem_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_push && !w_load) begin
                r_mem_count <= r_mem_count + CNT_ONE;
            end else if (!w_push && w_load) begin
                r_mem_count <= r_mem_count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
        end else if (flush) begin
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
        end else if (w_load) begin
            r_m_data  <= r_mem[r_rd_ptr];
            r_m_valid <= 1'b1;
            r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_data       = r_m_data;
    assign m_valid      = r_m_valid;
    assign level        = r_mem_count + {{LGFLEN{1'b0}}, r_m_valid};
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

endmodule

// File: tb/tb_stream_fifo_v2.sv
// Directed and table-driven bench for stream_fifo_v2 with an 8+1 word configuration.
module tb_stream_fifo_v2;

    localparam int W = 16;
    localparam int LGFLEN = 3;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LGFLEN:0] level;
    logic          almost_full;
    logic          almost_empty;

    int n_checks = 0;
    int n_errors = 0;

    stream_fifo_v2 #(
        .W      (W),
        .LGFLEN (LGFLEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sv;
        logic [15:0]  sd;
        logic         mr;
        logic         e_mv;
        logic [15:0]  e_md;
        int           e_lvl;
        logic         e_srdy;
        logic         e_af;
        logic         e_ae;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input int lvl);
        check({tag, " level"}, 32'(level), 32'(lvl));
        check({tag, " almost_full"}, 32'(almost_full), 32'(lvl >= 4));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(lvl <= 2));
    endtask

    vec_t vecs[13];

    initial begin
        int mc;
        logic mv;
        logic [15:0] q[$];
        int sent;
        int recvd;
        int cyc;
        logic push;
        logic load;
        logic pop;

        // Single word, then fill to capacity with m_ready low.
        vecs[0]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 1, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h1234, 1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 16'h0000, 2, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 16'h0000, 3, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0000, 4, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 16'h0000, 5, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0000, 6, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h0006, 1'b0, 1'b1, 16'h0000, 7, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 16'h0007, 1'b0, 1'b1, 16'h0000, 8, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 16'h0008, 1'b0, 1'b1, 16'h0000, 9, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 16'h0009, 1'b0, 1'b1, 16'h0000, 9, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) tick();
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset m_data", 32'(m_data), 32'd0);
        check("reset s_ready", 32'(s_ready), 32'd1);
        check_flags("reset", 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            m_ready = vecs[i].mr;
            tick();
            check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
            check($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vecs[i].e_md));
            check($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vecs[i].e_srdy));
            check_flags($sformatf("vec%0d", i), vecs[i].e_lvl);
        end
        s_valid = 1'b0;

        // Drain with m_ready toggling; each word must hold while m_ready is low.
        for (int i = 0; i < 9; i++) begin
            check($sformatf("drain%0d m_valid", i), 32'(m_valid), 32'd1);
            check($sformatf("drain%0d m_data", i), 32'(m_data), 32'(i));
            check($sformatf("drain%0d level", i), 32'(level), 32'(9 - i));
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            tick();
            if (i < 8) begin
                check($sformatf("hold%0d m_data", i), 32'(m_data), 32'(i + 1));
            end
        end
        check("drained m_valid", 32'(m_valid), 32'd0);
        check_flags("drained", 0);

        // Random streaming across pointer wrap against a small reference model.
        mc = 0; mv = 1'b0; sent = 0; recvd = 0; cyc = 0;
        while (recvd < 100 && cyc < 3000) begin
            s_valid = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_data  = 16'(sent + 16'h0100);
            m_ready = 1'($urandom_range(0, 1));
            check("rand s_ready", 32'(s_ready), 32'(mc != 8));
            check("rand m_valid", 32'(m_valid), 32'(mv));
            check("rand level", 32'(level), 32'(mc + int'(mv)));
            push = s_valid && (mc != 8);
            load = (!mv || m_ready) && (mc != 0);
            pop  = mv && m_ready;
            if (pop) begin
                check("rand m_data", 32'(m_data), 32'(q[0]));
                void'(q.pop_front());
                recvd++;
            end
            if (push) begin
                q.push_back(s_data);
                sent++;
            end
            tick();
            cyc++;
            mc = mc + int'(push) - int'(load);
            mv = load ? 1'b1 : (pop ? 1'b0 : mv);
        end
        check("rand words received", 32'(recvd), 32'd100);
        s_valid = 1'b0; m_ready = 1'b0;
        tick();
        check_flags("rand end", 0);

        // Flush at level 5 with a concurrent push attempt.
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h00F0 + i);
            tick();
        end
        check_flags("pre-flush", 5);
        flush = 1'b1; s_valid = 1'b1; s_data = 16'hBEEF;
        #1;
        check("flush s_ready", 32'(s_ready), 32'd0);
        tick();
        flush = 1'b0; s_valid = 1'b0;
        #1;
        check("post-flush m_valid", 32'(m_valid), 32'd0);
        check("post-flush s_ready", 32'(s_ready), 32'd1);
        check_flags("post-flush", 0);
        s_valid = 1'b1; s_data = 16'hCAFE; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        check("after-flush m_valid", 32'(m_valid), 32'd1);
        check("after-flush m_data", 32'(m_data), 32'hCAFE);
        tick();
        check("after-flush empty", 32'(m_valid), 32'd0);

        // Asynchronous reset between edges at level 6.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h0A00 + i);
            tick();
        end
        s_valid = 1'b0;
        check_flags("pre-reset", 6);
        #2;
        rst = 1'b1;
        #1;
        check("async m_valid", 32'(m_valid), 32'd0);
        check("async m_data", 32'(m_data), 32'd0);
        check("async s_ready", 32'(s_ready), 32'd1);
        check_flags("async", 0);
        tick();
        rst = 1'b0;
        s_valid = 1'b1; s_data = 16'h5555; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        check("post-reset m_valid", 32'(m_valid), 32'd1);
        check("post-reset m_data", 32'(m_data), 32'h5555);
        tick();
        check("post-reset empty", 32'(m_valid), 32'd0);
        check_flags("post-reset", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_fifo_v2.md
STREAM_FIFO_V2 -- requirements
Module: stream_fifo_v2

Interface
REQ-001 SHALL have parameter W, default 16, data word width in bits.
REQ-002 SHALL have parameter LGFLEN, default 7, log2 of storage depth; DEPTH = 2**LGFLEN.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-4, almost-full level threshold; legal range 1..DEPTH+1.
REQ-004 SHALL have parameter AE_THRESH, default 2, almost-empty level threshold; legal range 0..DEPTH.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port flush, input, 1, synchronous clear of all contents.
REQ-008 SHALL have port s_data, input, W, upstream data.
REQ-009 SHALL have port s_valid, input, 1, upstream word valid.
REQ-010 SHALL have port s_ready, output, 1, block can accept a word.
REQ-011 SHALL have port m_data, output, W, downstream data, registered.
REQ-012 SHALL have port m_valid, output, 1, downstream word valid, registered.
REQ-013 SHALL have port m_ready, input, 1, downstream accepts the word.
REQ-014 SHALL have port level, output, LGFLEN+1, words held (memory plus output register).
REQ-015 SHALL have port almost_full, output, 1, level >= AF_THRESH.
REQ-016 SHALL have port almost_empty, output, 1, level <= AE_THRESH.

Function
REQ-017 Storage SHALL be a DEPTH-entry memory plus one output register; total capacity DEPTH+1 words.
REQ-018 Write/read pointers SHALL be LGFLEN bits wide, wrap DEPTH-1 -> 0, and use a separate mem_count of LGFLEN+1 bits (0..DEPTH).
REQ-019 s_ready SHALL equal (mem_count != DEPTH) && !flush, combinational from registered state and flush only (no m_ready path).
REQ-020 Push SHALL occur on an edge where s_valid && s_ready: write mem[wr_ptr], wr_ptr+1.
REQ-021 Full memory SHALL block pushes even if a pop occurs the same cycle; no pass-through of s_data to m_data.
REQ-022 Output stage SHALL load when (!m_valid || m_ready) && mem_count != 0: m_data <= mem[rd_ptr], m_valid <= 1, rd_ptr+1.
REQ-023 If m_valid && m_ready and mem_count == 0, m_valid SHALL go to 0 on that edge.
REQ-024 If m_valid && !m_ready, m_data and m_valid SHALL hold unchanged (no drop, no duplicate).
REQ-025 Latency: a word pushed into an empty block on edge k SHALL be presented (m_valid=1) after edge k+1.
REQ-026 mem_count SHALL be +1 on push only, -1 on output load only, unchanged on both or neither.
REQ-027 level SHALL equal mem_count + m_valid at all times; range 0..DEPTH+1.
REQ-028 almost_full and almost_empty SHALL be combinational from level, with no extra latency.
REQ-029 Word order SHALL be strict FIFO; no word lost or duplicated across wrap-around of either pointer.
REQ-030 flush=1 SHALL on that edge clear wr_ptr, rd_ptr, mem_count and m_valid, ignoring s_valid and m_ready.
REQ-031 Memory contents SHALL NOT be cleared by flush or reset; only pointers and flags.

Reset
REQ-032 While rst=1, regardless of clk: wr_ptr=0, rd_ptr=0, mem_count=0, m_valid=0, m_data=0.
REQ-033 During and after reset: s_ready=1 (flush=0), level=0, almost_empty=1, almost_full=0.
REQ-034 Reset asserted mid-transfer SHALL discard all stored words; first push after release is the first word out.
REQ-035 Deassertion of rst SHALL be the only release condition; no internal reset sequencing cycles.

Verification
REQ-036 Single word: push 0x1234 at edge k, m_ready=1 -> m_valid=1, m_data=0x1234 after edge k+1; level 1 then 0.
REQ-037 Fill: LGFLEN=3, push 0..9 with m_ready=0 -> 9 words accepted (s_ready=0 after 9th), level=9, almost_full set at level 4 (default AF_THRESH).
REQ-038 Drain with backpressure: toggle m_ready 1/0 every cycle after fill -> outputs 0..8 in order, each held while m_ready=0, then m_valid=0, level=0.
REQ-039 Wrap: LGFLEN=3, 100 words streaming with random s_valid/m_ready -> output sequence identical to input; level never exceeds 9.
REQ-040 Flush: level=5, assert flush one cycle with s_valid=1 -> level=0, m_valid=0, pushed word discarded; next push returns it first.
REQ-041 Async reset: assert rst between edges with level=6 -> m_valid, level drop to 0 immediately; s_ready=1.
